// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 frames, or 8E1 when PARITY_EN is defined.
// Produces a parallel byte with a one-cycle valid strobe plus framing/parity error strobes.
module uart_rx #(
   parameter int CLKS_PER_BIT = 1302,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_serial,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 framing_error,
   output logic                 parity_error
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
   localparam int IW   = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   logic                 rx_meta_reg, rx_s_reg;
   state_t               state_reg, state_next;
   logic [CW-1:0]        count_reg, count_next;
   logic [IW-1:0]        idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [DATA_BITS-1:0] data_reg, data_next;
   logic                 valid_reg, valid_next;
   logic                 ferr_reg, ferr_next;
   logic [DATA_BITS-1:0] shift_in;
`ifdef PARITY_EN
   logic                 pbad_reg, pbad_next;
   logic                 perr_reg, perr_next;
`endif

   // New bit enters at the MSB so the first-received bit ends up at bit 0.
   assign shift_in = {rx_s_reg, shift_reg} >> 1;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_s_reg    <= 1'b1;
         state_reg   <= IDLE;
         count_reg   <= '0;
         idx_reg     <= '0;
         shift_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         ferr_reg    <= 1'b0;
`ifdef PARITY_EN
         pbad_reg    <= 1'b0;
         perr_reg    <= 1'b0;
`endif
      end else begin
         rx_meta_reg <= rx_serial;
         rx_s_reg    <= rx_meta_reg;
         state_reg   <= state_next;
         count_reg   <= count_next;
         idx_reg     <= idx_next;
         shift_reg   <= shift_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         ferr_reg    <= ferr_next;
`ifdef PARITY_EN
         pbad_reg    <= pbad_next;
         perr_reg    <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
`ifdef PARITY_EN
      pbad_next  = pbad_reg;
      perr_next  = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            count_next = '0;
            idx_next   = '0;
            if (!rx_s_reg) state_next = START;
         end
         START: begin
            // Re-check the line at mid start bit so short low glitches are dropped.
            if (count_reg == HALF_LAST) begin
               count_next = '0;
               idx_next   = '0;
               state_next = rx_s_reg ? IDLE : DATA;
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         DATA: begin
            if (count_reg == BIT_LAST) begin
               count_next = '0;
               shift_next = shift_in;
               idx_next   = idx_reg + IW'(1);
               if (idx_reg == IDX_LAST) begin
`ifdef PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         PARITY: begin
`ifdef PARITY_EN
            if (count_reg == BIT_LAST) begin
               count_next = '0;
               pbad_next  = rx_s_reg ^ (^shift_reg);
               state_next = STOP;
            end else begin
               count_next = count_reg + CW'(1);
            end
`else
            state_next = IDLE;
`endif
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            if (count_reg == BIT_LAST) begin
               count_next = '0;
               if (rx_s_reg) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
`ifdef PARITY_EN
                  perr_next  = pbad_reg;
`endif
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end else begin
               count_next = count_reg + CW'(1);
            end
         end
         WAIT_HIGH: begin
            if (rx_s_reg) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign rx_data       = data_reg;
   assign rx_valid      = valid_reg;
   assign rx_busy       = (state_reg != IDLE);
   assign framing_error = ferr_reg;
`ifdef PARITY_EN
   assign parity_error  = perr_reg;
`else
   assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a frame-level model queues the expected
// strobe for every frame sent; a negedge monitor pops and compares on each DUT strobe.
module tb_uart_rx;
   localparam int CPB = 16;

   typedef struct {
      logic [7:0] data;
      bit         ferr;
      bit         perr;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx_serial = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, framing_error, parity_error;

   exp_t       exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         n_vec = 0;
   int         n_err = 0;
   longint     cyc = 0;
   longint     t_start = 0;
   longint     t_valid = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clock(clock),
      .reset(reset),
      .rx_serial(rx_serial),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_busy(rx_busy),
      .framing_error(framing_error),
      .parity_error(parity_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Hold the line at v for n clocks; changes always land 1 time unit after a posedge.
   task automatic drive_bit(input bit v, input int n);
      rx_serial = v;
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Queue the expected outcome of one frame, then transmit it.
   task automatic send_frame(input logic [7:0] d, input bit good_stop, input int stop_len,
                             input bit par_bit);
      exp_t e;
      if (good_stop) begin
         e.data = d;
         e.ferr = 1'b0;
`ifdef PARITY_EN
         e.perr = (par_bit != ^d);
`else
         e.perr = 1'b0;
`endif
         last_good = d;
      end else begin
         e.data = last_good;
         e.ferr = 1'b1;
         e.perr = 1'b0;
      end
      exp_q.push_back(e);
      $display("frame tx data=%02h stop=%0d par=%0d", d, good_stop, par_bit);
      t_start = cyc;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef PARITY_EN
      drive_bit(par_bit, CPB);
`endif
      drive_bit(good_stop, stop_len);
      if (!good_stop) drive_bit(1'b1, CPB);
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset) begin
         if (rx_valid && framing_error) check("valid_and_ferr_together", 1, 0);
         if (rx_valid || framing_error) begin
            if (rx_valid) t_valid = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {rx_valid, framing_error}, 2'b00);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               $display("frame rx data=%02h valid=%0d ferr=%0d perr=%0d (exp data=%02h ferr=%0d perr=%0d)",
                        rx_data, rx_valid, framing_error, parity_error, e.data, e.ferr, e.perr);
               check("strobe_ferr", framing_error, e.ferr);
               check("strobe_valid", rx_valid, !e.ferr);
               check("strobe_data", rx_data, e.data);
               check("strobe_perr", parity_error, e.perr);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      check("reset_data", rx_data, 8'h00);
      check("reset_outs", {rx_valid, rx_busy, framing_error, parity_error}, 4'b0000);
      reset = 1'b0;
      drive_bit(1'b1, 2 * CPB);

      // Single frame, latency and busy
      fork
         send_frame(8'h55, 1'b1, CPB, ^8'h55);
         begin
            repeat (3 * CPB) @(posedge clock);
            #1;
            check("busy_mid_frame", rx_busy, 1'b1);
         end
      join
      drive_bit(1'b1, 2 * CPB);
      check("latency_155pm5", ((t_valid - t_start) >= 150) && ((t_valid - t_start) <= 160), 1'b1);

      // Back-to-back frames, no idle gap
      send_frame(8'hA3, 1'b1, CPB, ^8'hA3);
      send_frame(8'h0F, 1'b1, CPB, ^8'h0F);
      send_frame(8'hFF, 1'b1, CPB, ^8'hFF);
      drive_bit(1'b1, 2 * CPB);
      check("b2b_drained", exp_q.size(), 0);

      // Short low glitch is rejected
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 12);
      check("glitch_busy_low", rx_busy, 1'b0);
      drive_bit(1'b1, CPB);

      // Stop bit held low: framing error, data held, then recovery
      send_frame(8'h3C, 1'b0, 40, 1'b0);
      send_frame(8'h81, 1'b1, CPB, ^8'h81);
      drive_bit(1'b1, 2 * CPB);

      // Reset in the middle of the data bits
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive_bit(bit'((8'hC6 >> i) & 8'h01), CPB);
      reset = 1'b1;
      rx_serial = 1'b1;
      @(posedge clock);
      #1;
      check("midreset_data", rx_data, 8'h00);
      check("midreset_outs", {rx_valid, rx_busy, framing_error, parity_error}, 4'b0000);
      reset = 1'b0;
      last_good = 8'h00;
      drive_bit(1'b1, 2 * CPB);
      send_frame(8'h12, 1'b1, CPB, ^8'h12);
      drive_bit(1'b1, 2 * CPB);

`ifdef PARITY_EN
      send_frame(8'h07, 1'b1, CPB, 1'b1);
      drive_bit(1'b1, CPB);
      send_frame(8'h07, 1'b1, CPB, 1'b0);
      drive_bit(1'b1, CPB);
`endif

      // Random frames, random gaps, occasional broken stop bit
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         bit good;
         d = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 5) != 0);
         send_frame(d, good, good ? CPB : CPB + int'($urandom_range(0, 20)),
                    1'($urandom_range(0, 1)));
         drive_bit(1'b1, int'($urandom_range(0, 3 * CPB)));
      end

      for (int k = 0; k < 40 * CPB && exp_q.size() != 0; k++) @(posedge clock);
      drive_bit(1'b1, 2 * CPB);
      check("all_frames_seen", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
